// File: rtl/icb_dma_pkg.sv
// Shared register map, CTRL/STAT bit positions and FSM encoding for icb_dma.
package icb_dma_pkg;

    localparam logic [7:0] REG_CTRL = 8'h00;
    localparam logic [7:0] REG_STAT = 8'h04;
    localparam logic [7:0] REG_SRC  = 8'h08;
    localparam logic [7:0] REG_DST  = 8'h0C;
    localparam logic [7:0] REG_LEN  = 8'h10;

    localparam int CTRL_START   = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int CTRL_SRC_INC = 2;
    localparam int CTRL_DST_INC = 3;
    localparam int CTRL_FILL    = 4;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_CMD = 3'd1,
        ST_RD_RSP = 3'd2,
        ST_WR_CMD = 3'd3,
        ST_WR_RSP = 3'd4
    } dma_state_e;

endpackage

// File: rtl/icb_dma.sv
// Single-channel word DMA with an ICB master port and a small register block.
// Build option DMA_FILL_EN adds CTRL.FILL: write the SRC value to every destination word.
module icb_dma
    import icb_dma_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  waddr_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  sel_i,
    input  logic        we_i,
    input  logic [7:0]  raddr_i,
    input  logic        rd_i,
    output logic [31:0] data_o,
    output logic        m_icb_cmd_valid,
    input  logic        m_icb_cmd_ready,
    output logic [31:0] m_icb_cmd_addr,
    output logic        m_icb_cmd_read,
    output logic [31:0] m_icb_cmd_wdata,
    output logic [3:0]  m_icb_cmd_wmask,
    input  logic        m_icb_rsp_valid,
    output logic        m_icb_rsp_ready,
    input  logic        m_icb_rsp_err,
    input  logic [31:0] m_icb_rsp_rdata,
    output logic        irq_dma_done
);

    dma_state_e  state, state_nxt;
    logic        busy;
    logic        irq_en, src_inc, dst_inc, fill;
    logic        done, err;
    logic [31:2] src, dst, src_w, dst_w;
    logic [15:0] len, len_w;
    logic [31:0] buf_q, rdata;
    logic        cfg_we, stat_we, start_req, start_go, start_fill;
    logic        ld_buf, word_done, xfer_end, xfer_abort;

    assign busy      = (state != ST_IDLE);
    assign cfg_we    = we_i && !busy;
    assign stat_we   = we_i && (waddr_i == REG_STAT) && sel_i[0];
    assign start_req = cfg_we && (waddr_i == REG_CTRL) && sel_i[0] && data_i[CTRL_START];
    assign start_go  = start_req && (len != 16'd0);

`ifdef DMA_FILL_EN
    // Address bits [1:0] always read back as 0, but the fill pattern needs the full word.
    logic [1:0] src_lo;
    // FILL arrives in the same CTRL write as START, so take it from the bus.
    assign start_fill = data_i[CTRL_FILL];
`else
    assign fill       = 1'b0;
    assign start_fill = 1'b0;
`endif

    // Programmed configuration; frozen while a transfer runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en  <= 1'b0;
            src_inc <= 1'b0;
            dst_inc <= 1'b0;
            src     <= '0;
            dst     <= '0;
            len     <= '0;
`ifdef DMA_FILL_EN
            fill    <= 1'b0;
            src_lo  <= 2'b00;
`endif
        end else if (cfg_we) begin
            case (waddr_i)
                REG_CTRL: if (sel_i[0]) begin
                    irq_en  <= data_i[CTRL_IRQ_EN];
                    src_inc <= data_i[CTRL_SRC_INC];
                    dst_inc <= data_i[CTRL_DST_INC];
`ifdef DMA_FILL_EN
                    fill    <= data_i[CTRL_FILL];
`endif
                end
                REG_SRC: begin
                    if (sel_i[0]) src[7:2] <= data_i[7:2];
`ifdef DMA_FILL_EN
                    if (sel_i[0]) src_lo <= data_i[1:0];
`endif
                    for (int b = 1; b < 4; b++)
                        if (sel_i[b]) src[8*b +: 8] <= data_i[8*b +: 8];
                end
                REG_DST: begin
                    if (sel_i[0]) dst[7:2] <= data_i[7:2];
                    for (int b = 1; b < 4; b++)
                        if (sel_i[b]) dst[8*b +: 8] <= data_i[8*b +: 8];
                end
                REG_LEN: begin
                    if (sel_i[0]) len[7:0]  <= data_i[7:0];
                    if (sel_i[1]) len[15:8] <= data_i[15:8];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        m_icb_cmd_valid = 1'b0;
        m_icb_cmd_read  = 1'b0;
        m_icb_cmd_addr  = '0;
        m_icb_cmd_wdata = '0;
        m_icb_cmd_wmask = '0;
        m_icb_rsp_ready = 1'b0;
        ld_buf          = 1'b0;
        word_done       = 1'b0;
        xfer_end        = 1'b0;
        xfer_abort      = 1'b0;
        case (state)
            ST_IDLE: if (start_go) state_nxt = start_fill ? ST_WR_CMD : ST_RD_CMD;
            ST_RD_CMD: begin
                m_icb_cmd_valid = 1'b1;
                m_icb_cmd_read  = 1'b1;
                m_icb_cmd_addr  = {src_w, 2'b00};
                if (m_icb_cmd_ready) state_nxt = ST_RD_RSP;
            end
            ST_RD_RSP: begin
                m_icb_rsp_ready = 1'b1;
                if (m_icb_rsp_valid) begin
                    if (m_icb_rsp_err) begin
                        xfer_abort = 1'b1;
                        state_nxt  = ST_IDLE;
                    end else begin
                        ld_buf    = 1'b1;
                        state_nxt = ST_WR_CMD;
                    end
                end
            end
            ST_WR_CMD: begin
                m_icb_cmd_valid = 1'b1;
                m_icb_cmd_addr  = {dst_w, 2'b00};
                m_icb_cmd_wdata = buf_q;
                m_icb_cmd_wmask = 4'hF;
                if (m_icb_cmd_ready) state_nxt = ST_WR_RSP;
            end
            ST_WR_RSP: begin
                m_icb_rsp_ready = 1'b1;
                if (m_icb_rsp_valid) begin
                    if (m_icb_rsp_err) begin
                        xfer_abort = 1'b1;
                        state_nxt  = ST_IDLE;
                    end else begin
                        word_done = 1'b1;
                        if (len_w > 16'd1) begin
                            state_nxt = fill ? ST_WR_CMD : ST_RD_CMD;
                        end else begin
                            xfer_end  = 1'b1;
                            state_nxt = ST_IDLE;
                        end
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Working copies, data buffer and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_w <= '0;
            dst_w <= '0;
            len_w <= '0;
            buf_q <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            if (cfg_we && waddr_i == REG_LEN) begin
                if (sel_i[0]) len_w[7:0]  <= data_i[7:0];
                if (sel_i[1]) len_w[15:8] <= data_i[15:8];
            end
            if (start_go) begin
                src_w <= src;
                dst_w <= dst;
                len_w <= len;
`ifdef DMA_FILL_EN
                if (start_fill) buf_q <= {src, src_lo};
`endif
            end
            if (ld_buf) buf_q <= m_icb_rsp_rdata;
            if (word_done) begin
                len_w <= len_w - 16'd1;
                if (src_inc) src_w <= src_w + 30'd1;
                if (dst_inc) dst_w <= dst_w + 30'd1;
            end
            // Clear first so a completion on the same edge wins.
            if (stat_we && data_i[STAT_DONE]) done <= 1'b0;
            if (stat_we && data_i[STAT_ERR])  err  <= 1'b0;
            if (start_go) begin
                done <= 1'b0;
                err  <= 1'b0;
            end
            if ((start_req && len == 16'd0) || xfer_end) done <= 1'b1;
            if (xfer_abort) begin
                done <= 1'b1;
                err  <= 1'b1;
            end
        end
    end

    // LEN reads the working count so an aborted transfer shows what is left.
    always_comb begin
        rdata = '0;
        case (raddr_i)
            REG_CTRL: rdata = {27'd0, fill, dst_inc, src_inc, irq_en, 1'b0};
            REG_STAT: rdata = {29'd0, err, done, busy};
            REG_SRC:  rdata = {src, 2'b00};
            REG_DST:  rdata = {dst, 2'b00};
            REG_LEN:  rdata = {16'd0, len_w};
            default:  rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    data_o <= '0;
        else if (rd_i) data_o <= rdata;
    end

    assign irq_dma_done = done & irq_en;

endmodule

// File: tb/tb_icb_dma.sv
// Randomized bench for icb_dma: ICB memory slave with stalls/errors and a transfer-level reference model.
module tb_icb_dma;
    import icb_dma_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  waddr_i = '0;
    logic [31:0] data_i = '0;
    logic [3:0]  sel_i = '0;
    logic        we_i = 1'b0;
    logic [7:0]  raddr_i = '0;
    logic        rd_i = 1'b0;
    logic [31:0] data_o;
    logic        m_icb_cmd_valid, m_icb_cmd_ready, m_icb_cmd_read;
    logic [31:0] m_icb_cmd_addr, m_icb_cmd_wdata;
    logic [3:0]  m_icb_cmd_wmask;
    logic        m_icb_rsp_valid, m_icb_rsp_ready, m_icb_rsp_err;
    logic [31:0] m_icb_rsp_rdata;
    logic        irq_dma_done;

    icb_dma dut (
        .clk(clk), .rst_n(rst_n),
        .waddr_i(waddr_i), .data_i(data_i), .sel_i(sel_i), .we_i(we_i),
        .raddr_i(raddr_i), .rd_i(rd_i), .data_o(data_o),
        .m_icb_cmd_valid(m_icb_cmd_valid), .m_icb_cmd_ready(m_icb_cmd_ready),
        .m_icb_cmd_addr(m_icb_cmd_addr), .m_icb_cmd_read(m_icb_cmd_read),
        .m_icb_cmd_wdata(m_icb_cmd_wdata), .m_icb_cmd_wmask(m_icb_cmd_wmask),
        .m_icb_rsp_valid(m_icb_rsp_valid), .m_icb_rsp_ready(m_icb_rsp_ready),
        .m_icb_rsp_err(m_icb_rsp_err), .m_icb_rsp_rdata(m_icb_rsp_rdata),
        .irq_dma_done(irq_dma_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit        rd;
        bit [31:0] addr;
        bit [31:0] data;
        bit [3:0]  mask;
    } txn_t;

    bit [31:0] mem [bit [31:0]];
    txn_t      obs [$];

    // Slave knobs and bookkeeping
    int        stall_cyc = 0;
    bit        stall_rand = 0;
    bit        rsp_rand = 0;
    int        err_rd_idx = 0;
    int        rd_cnt = 0;
    int        cmd_valid_cycles = 0;
    int        unstable = 0;
    bit        rsp_pend, rsp_err_n, rsp_is_wr, holding, last_cmd_fire, last_rsp_fire;
    bit [31:0] rsp_data_n;
    int        rsp_dly, wait_cnt, stall_tgt;
    logic        hold_rd;
    logic [31:0] hold_addr, hold_wdata;
    logic [3:0]  hold_mask;

    function automatic bit [31:0] mem_rd(input bit [31:0] a);
        return mem.exists(a) ? mem[a] : ~a;
    endfunction

    // ICB memory slave: acts on falling edges, DUT samples on rising edges.
    initial begin
        m_icb_cmd_ready = 1'b0;
        m_icb_rsp_valid = 1'b0;
        m_icb_rsp_err   = 1'b0;
        m_icb_rsp_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_icb_cmd_ready = 1'b0;
                m_icb_rsp_valid = 1'b0;
                m_icb_rsp_err   = 1'b0;
                rsp_pend = 0; holding = 0; last_cmd_fire = 0; last_rsp_fire = 0;
                continue;
            end
            if (last_rsp_fire) begin
                m_icb_rsp_valid = 1'b0;
                m_icb_rsp_err   = 1'b0;
            end
            if (last_cmd_fire) begin
                txn_t t;
                t.rd = hold_rd; t.addr = hold_addr; t.mask = hold_mask;
                if (hold_rd) begin
                    rd_cnt++;
                    t.data = mem_rd(hold_addr);
                    rsp_err_n = (rd_cnt == err_rd_idx);
                end else begin
                    t.data = hold_wdata;
                    mem[hold_addr] = hold_wdata;
                    rsp_err_n = 0;
                end
                obs.push_back(t);
                rsp_pend   = 1;
                rsp_data_n = hold_rd ? t.data : 32'd0;
                rsp_is_wr  = !hold_rd;
                rsp_dly    = rsp_rand ? int'($urandom_range(0, 2)) : 0;
            end
            if (rsp_pend) begin
                if (rsp_dly > 0) rsp_dly--;
                else begin
                    m_icb_rsp_valid = 1'b1;
                    m_icb_rsp_err   = rsp_err_n;
                    m_icb_rsp_rdata = rsp_data_n;
                    rsp_pend = 0;
                end
            end
            if (m_icb_cmd_valid) begin
                cmd_valid_cycles++;
                if (holding) begin
                    if (m_icb_cmd_addr !== hold_addr || m_icb_cmd_read !== hold_rd ||
                        m_icb_cmd_wdata !== hold_wdata || m_icb_cmd_wmask !== hold_mask)
                        unstable++;
                end else begin
                    holding    = 1;
                    hold_rd    = m_icb_cmd_read;
                    hold_addr  = m_icb_cmd_addr;
                    hold_wdata = m_icb_cmd_wdata;
                    hold_mask  = m_icb_cmd_wmask;
                    wait_cnt   = 0;
                    stall_tgt  = stall_rand ? int'($urandom_range(0, 2)) : stall_cyc;
                end
                if (wait_cnt < stall_tgt) begin
                    m_icb_cmd_ready = 1'b0;
                    wait_cnt++;
                end else m_icb_cmd_ready = 1'b1;
            end else m_icb_cmd_ready = 1'b0;
            last_cmd_fire = m_icb_cmd_valid && m_icb_cmd_ready;
            if (last_cmd_fire) holding = 0;
            last_rsp_fire = m_icb_rsp_valid && m_icb_rsp_ready;
        end
    end

    task automatic reg_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        waddr_i = a; data_i = d; sel_i = s; we_i = 1'b1;
        @(negedge clk);
        we_i = 1'b0;
    endtask

    task automatic reg_rd(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        raddr_i = a; rd_i = 1'b1;
        @(negedge clk);
        rd_i = 1'b0;
        d = data_o;
    endtask

    task automatic wait_idle(input string nm);
        logic [31:0] st;
        int n = 0;
        do begin
            reg_rd(REG_STAT, st);
            n++;
        end while (st[STAT_BUSY] && n < 400);
        if (st[STAT_BUSY]) chk({nm, "_timeout"}, 64'd1, 64'd0);
    endtask

    // Reference: word-by-word read/write sequence derived from the transfer rules.
    task automatic run_xfer(input string nm, input bit [31:0] s, input bit [31:0] d,
                            input bit [15:0] l, input bit si, input bit di, input int err_idx);
        bit [31:0] mem_ref [bit [31:0]];
        txn_t      exp_q [$];
        txn_t      t;
        bit [31:0] es, ed, rdat;
        int        rem;
        bit        e_err;
        logic [31:0] v;
        mem_ref = mem;
        es = s & ~32'h3; ed = d & ~32'h3; rem = l; e_err = 0;
        for (int i = 0; i < int'(l); i++) begin
            rdat = mem_ref.exists(es) ? mem_ref[es] : ~es;
            t.rd = 1; t.addr = es; t.data = rdat; t.mask = 4'h0;
            exp_q.push_back(t);
            if (i + 1 == err_idx) begin e_err = 1; break; end
            t.rd = 0; t.addr = ed; t.data = rdat; t.mask = 4'hF;
            exp_q.push_back(t);
            mem_ref[ed] = rdat;
            rem--;
            if (si) es += 32'd4;
            if (di) ed += 32'd4;
        end
        obs.delete(); rd_cnt = 0; err_rd_idx = err_idx; cmd_valid_cycles = 0; unstable = 0;
        reg_wr(REG_SRC, s, 4'hF);
        reg_wr(REG_DST, d, 4'hF);
        reg_wr(REG_LEN, {16'd0, l}, 4'hF);
        reg_wr(REG_CTRL, {28'd0, di, si, 1'b1, 1'b1}, 4'h1);
        if (l != 0) reg_wr(REG_SRC, 32'hFFFF_FFF0, 4'hF);
        wait_idle(nm);
        chk({nm, "_ntxn"}, obs.size(), exp_q.size());
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_rd%0d", nm, i), obs[i].rd, exp_q[i].rd);
            chk($sformatf("%s_ad%0d", nm, i), {obs[i].addr, obs[i].data}, {exp_q[i].addr, exp_q[i].data});
            if (!exp_q[i].rd) chk($sformatf("%s_mask%0d", nm, i), obs[i].mask, 4'hF);
        end
        reg_rd(REG_STAT, v);
        chk({nm, "_stat"}, v, {29'd0, e_err, 1'b1, 1'b0});
        reg_rd(REG_LEN, v);
        chk({nm, "_len"}, v, rem);
        reg_rd(REG_SRC, v);
        chk({nm, "_src"}, v, s & ~32'h3);
        chk({nm, "_stable"}, unstable, 0);
        chk({nm, "_irq"}, irq_dma_done, 1'b1);
    endtask

    initial begin
        logic [31:0] v;
        bit [31:0]   w [3];
        int          n;
        repeat (3) @(negedge clk);
        chk("rst_cmd_valid", m_icb_cmd_valid, 1'b0);
        chk("rst_irq", irq_dma_done, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            reg_rd(8'(i * 4), v);
            chk($sformatf("rst_reg%0d", i), v, 32'd0);
        end

        for (int i = 0; i < 3; i++) begin
            w[i] = $urandom;
            mem[32'h100 + 32'(i * 4)] = w[i];
        end
        run_xfer("basic", 32'h100, 32'h200, 16'd3, 1, 1, 0);

        stall_cyc = 3;
        run_xfer("stall", 32'h100, 32'h200, 16'd3, 1, 0, 0);
        chk("stall_last", mem[32'h200], w[2]);
        stall_cyc = 0;

        run_xfer("err", 32'h100, 32'h300, 16'd4, 1, 1, 2);
        run_xfer("wrap", 32'hFFFF_FFF8, 32'h400, 16'd3, 1, 1, 0);

        // Zero length: done without bus traffic, irq tracks DONE & IRQ_EN
        cmd_valid_cycles = 0;
        reg_wr(REG_LEN, 32'd0, 4'hF);
        reg_wr(REG_CTRL, 32'h3, 4'h1);
        chk("len0_irq", irq_dma_done, 1'b1);
        reg_rd(REG_STAT, v);
        chk("len0_stat", v, 32'h2);
        repeat (4) @(negedge clk);
        chk("len0_nocmd", cmd_valid_cycles, 0);
        reg_wr(REG_STAT, 32'h2, 4'hF);
        chk("len0_irq_clr", irq_dma_done, 1'b0);

        // DONE clear colliding with completion: completion wins
        reg_wr(REG_SRC, 32'h100, 4'hF);
        reg_wr(REG_DST, 32'h500, 4'hF);
        reg_wr(REG_LEN, 32'd1, 4'hF);
        reg_wr(REG_CTRL, 32'h3, 4'h1);
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!(m_icb_rsp_valid && m_icb_rsp_ready && rsp_is_wr) && n < 50);
        chk("race_seen", n < 50, 1'b1);
        waddr_i = REG_STAT; data_i = 32'h2; sel_i = 4'hF; we_i = 1'b1;
        @(negedge clk);
        we_i = 1'b0;
        reg_rd(REG_STAT, v);
        chk("race_stat", v, 32'h2);
        chk("race_irq", irq_dma_done, 1'b1);

        stall_rand = 1; rsp_rand = 1;
        for (int k = 0; k < 256; k++) mem[32'h1000 + 32'(k * 4)] = $urandom;
        for (int it = 0; it < 8; it++) begin
            bit [31:0] s, d;
            bit [15:0] l;
            int        e;
            s = 32'h1000 + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3);
            d = 32'h1000 + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3);
            l = 16'($urandom_range(1, 6));
            e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, l)) : 0;
            run_xfer($sformatf("rnd%0d", it), s, d, l, 1'($urandom), 1'($urandom), e);
        end
        stall_rand = 0; rsp_rand = 0;

        // Reset while a write command is stalled
        stall_cyc = 20;
        reg_wr(REG_SRC, 32'h100, 4'hF);
        reg_wr(REG_DST, 32'h600, 4'hF);
        reg_wr(REG_LEN, 32'd2, 4'hF);
        reg_wr(REG_CTRL, 32'hF, 4'h1);
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!(m_icb_cmd_valid && !m_icb_cmd_read) && n < 60);
        chk("rstmid_seen", n < 60, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_valid", m_icb_cmd_valid, 1'b0);
        chk("rstmid_rsp_ready", m_icb_rsp_ready, 1'b0);
        chk("rstmid_dout", data_o, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stall_cyc = 0;
        for (int i = 0; i < 5; i++) begin
            reg_rd(8'(i * 4), v);
            chk($sformatf("rstmid_reg%0d", i), v, 32'd0);
        end
        repeat (5) @(negedge clk);
        chk("rstmid_quiet", m_icb_cmd_valid, 1'b0);

`ifdef DMA_FILL_EN
        obs.delete(); rd_cnt = 0; err_rd_idx = 0;
        reg_wr(REG_SRC, 32'hDEAD_BEEF, 4'hF);
        reg_wr(REG_DST, 32'h700, 4'hF);
        reg_wr(REG_LEN, 32'd2, 4'hF);
        reg_wr(REG_CTRL, 32'h19, 4'h1);
        wait_idle("fill");
        chk("fill_ntxn", obs.size(), 2);
        for (int i = 0; i < obs.size() && i < 2; i++) begin
            chk($sformatf("fill_rd%0d", i), obs[i].rd, 1'b0);
            chk($sformatf("fill_ad%0d", i), {obs[i].addr, obs[i].data},
                {32'h700 + 32'(i * 4), 32'hDEAD_BEEF});
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1);
    end

endmodule
